// File: rtl/lutram_port_controller_pkg.sv
// Shared definitions for the LUTRAM port controller: the FSM state encoding
// and a helper that gives the last set index visited by the clear sweep.
package lutram_port_controller_pkg;

  // Controller modes: clearing storage after reset, then normal service.
  typedef enum logic [0:0] {
    CTRL_INIT = 1'b0,
    CTRL_RUN  = 1'b1
  } ctrl_state_e;

  // Terminal count of the clear sweep (last set index). Callers cast it
  // to their set pointer width.
  function automatic int sweep_terminal_count(input int number_sets);
    return number_sets - 1;
  endfunction

endpackage

// File: rtl/lutram_port_controller_if.sv
// Client-side request/response channel of the LUTRAM port controller.
// Signal names keep the controller's point of view (_in = into controller).
interface lutram_port_controller_if #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 6
) ();

  logic                  request_valid_in;
  logic                  request_ready_out;
  logic                  request_write_in;
  logic [ADDR_WIDTH-1:0] request_set_addr_in;
  logic [DATA_WIDTH-1:0] request_data_in;
  logic                  response_valid_out;
  logic                  response_ready_in;
  logic [DATA_WIDTH-1:0] response_data_out;

  // Client pipeline side.
  modport master (
    output request_valid_in,
    output request_write_in,
    output request_set_addr_in,
    output request_data_in,
    output response_ready_in,
    input  request_ready_out,
    input  response_valid_out,
    input  response_data_out
  );

  // Controller side.
  modport slave (
    input  request_valid_in,
    input  request_write_in,
    input  request_set_addr_in,
    input  request_data_in,
    input  response_ready_in,
    output request_ready_out,
    output response_valid_out,
    output response_data_out
  );

endinterface

// File: rtl/lutram_port_response_reg.sv
// One-entry response holding register with a valid/ready handshake.
// A load always wins over a consume at the same edge, so a consumer that
// keeps ready high sees back-to-back responses with no bubble.
module lutram_port_response_reg #(
  parameter int DATA_WIDTH = 64
) (
  input  logic                  clk_in,
  input  logic                  reset_in,
  input  logic                  load_in,
  input  logic [DATA_WIDTH-1:0] load_data_in,
  input  logic                  ready_in,
  output logic                  valid_out,
  output logic [DATA_WIDTH-1:0] data_out
);

  logic                  valid_reg;
  logic                  valid_next;
  logic [DATA_WIDTH-1:0] data_reg;
  logic [DATA_WIDTH-1:0] data_next;

  // Next-entry selection: load replaces, consume empties, otherwise hold.
  always_comb begin
    valid_next = valid_reg;
    data_next  = data_reg;
    if (load_in) begin
      valid_next = 1'b1;
      data_next  = load_data_in;
    end else if (ready_in) begin
      valid_next = 1'b0;
    end
  end

  // Entry storage, cleared by reset.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      valid_reg <= 1'b0;
      data_reg  <= '0;
    end else begin
      valid_reg <= valid_next;
      data_reg  <= data_next;
    end
  end

  assign valid_out = valid_reg;
  assign data_out  = data_reg;

endmodule

// File: rtl/lutram_port_controller.sv
// Initiator-side front end for single-port LUTRAM storage. After reset it
// zeroes every set, then maps a valid/ready request stream onto storage port
// accesses and returns read data through a registered response channel.
// Optional feature macro: LUTRAM_PORT_CONTROLLER_WRITE_ACK_EN -- when defined,
// accepted writes also return a response echoing the written data.
module lutram_port_controller
  import lutram_port_controller_pkg::*;
#(
  parameter int SINGLE_ELEMENT_SIZE_IN_BITS = 64,
  parameter int NUMBER_SETS                 = 64,
  parameter int SET_PTR_WIDTH_IN_BITS       = $clog2(NUMBER_SETS)
) (
  input  logic                                   clk_in,
  input  logic                                   reset_in,
  lutram_port_controller_if.slave                client,
  output logic                                   init_done_out,
  output logic                                   access_en_out,
  output logic                                   write_en_out,
  output logic [SET_PTR_WIDTH_IN_BITS-1:0]       access_set_addr_out,
  output logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] write_element_out,
  input  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] read_element_in
);

  localparam logic [SET_PTR_WIDTH_IN_BITS-1:0] SWEEP_LAST =
    SET_PTR_WIDTH_IN_BITS'(sweep_terminal_count(NUMBER_SETS));

  ctrl_state_e                      state_reg;
  ctrl_state_e                      state_next;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] sweep_reg;
  logic [SET_PTR_WIDTH_IN_BITS-1:0] sweep_next;

  logic                                   request_accept;
  logic                                   response_load;
  logic [SINGLE_ELEMENT_SIZE_IN_BITS-1:0] response_load_data;

  // State and sweep counter registers; reset restarts the clear sweep.
  always_ff @(posedge clk_in) begin
    if (reset_in) begin
      state_reg <= CTRL_INIT;
      sweep_reg <= '0;
    end else begin
      state_reg <= state_next;
      sweep_reg <= sweep_next;
    end
  end

  // Sweep advance: stop at the last set (saturating) and enter service mode.
  always_comb begin
    state_next = state_reg;
    sweep_next = sweep_reg;
    if (state_reg == CTRL_INIT) begin
      if (sweep_reg == SWEEP_LAST) begin
        state_next = CTRL_RUN;
      end else begin
        sweep_next = sweep_reg + 1'b1;
      end
    end
  end

  // Storage and client drive; reset_in gates everything combinationally so
  // nothing is accepted or written while reset is held.
  always_comb begin
    client.request_ready_out = 1'b0;
    request_accept           = 1'b0;
    access_en_out            = 1'b0;
    write_en_out             = 1'b0;
    access_set_addr_out      = sweep_reg;
    write_element_out        = '0;
    if (!reset_in) begin
      if (state_reg == CTRL_INIT) begin
        access_en_out = 1'b1;
        write_en_out  = 1'b1;
      end else begin
        client.request_ready_out = !client.response_valid_out || client.response_ready_in;
        request_accept           = client.request_valid_in && client.request_ready_out;
        access_en_out            = request_accept;
        write_en_out             = request_accept && client.request_write_in;
        access_set_addr_out      = client.request_set_addr_in;
        write_element_out        = client.request_data_in;
      end
    end
  end

`ifdef LUTRAM_PORT_CONTROLLER_WRITE_ACK_EN
  // Every accepted request answers; writes echo their own data.
  assign response_load      = request_accept;
  assign response_load_data = client.request_write_in ? client.request_data_in : read_element_in;
`else
  // Writes are posted; only reads produce a response.
  assign response_load      = request_accept && !client.request_write_in;
  assign response_load_data = read_element_in;
`endif

  assign init_done_out = (state_reg == CTRL_RUN);

  lutram_port_response_reg #(
    .DATA_WIDTH (SINGLE_ELEMENT_SIZE_IN_BITS)
  ) u_response_reg (
    .clk_in       (clk_in),
    .reset_in     (reset_in),
    .load_in      (response_load),
    .load_data_in (response_load_data),
    .ready_in     (client.response_ready_in),
    .valid_out    (client.response_valid_out),
    .data_out     (client.response_data_out)
  );

endmodule

// File: tb/tb_lutram_port_controller.sv
// Self-checking bench for lutram_port_controller: a behavioural LUTRAM on
// the storage pins plus a reference model of set contents and the pending
// response, driven by directed scenarios and randomized traffic.
module tb_lutram_port_controller;

  localparam int DW = 64;
  localparam int NS = 64;
  localparam int AW = $clog2(NS);
`ifdef LUTRAM_PORT_CONTROLLER_WRITE_ACK_EN
  localparam bit WACK = 1'b1;
`else
  localparam bit WACK = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          init_done;
  logic          access_en;
  logic          write_en;
  logic [AW-1:0] access_addr;
  logic [DW-1:0] write_elem;
  logic [DW-1:0] read_elem;
  logic          scramble = 1'b1;

  logic [DW-1:0] mem     [NS];
  logic [DW-1:0] ref_mem [NS];

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  lutram_port_controller_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  lutram_port_controller #(
    .SINGLE_ELEMENT_SIZE_IN_BITS (DW),
    .NUMBER_SETS                 (NS),
    .SET_PTR_WIDTH_IN_BITS       (AW)
  ) dut (
    .clk_in              (clk),
    .reset_in            (rst),
    .client              (bus),
    .init_done_out       (init_done),
    .access_en_out       (access_en),
    .write_en_out        (write_en),
    .access_set_addr_out (access_addr),
    .write_element_out   (write_elem),
    .read_element_in     (read_elem)
  );

  // Behavioural single-port LUTRAM; scramble fills it with garbage so the
  // clear sweep has to do real work.
  always @(posedge clk) begin
    if (scramble) begin
      for (int i = 0; i < NS; i++) mem[i] <= {$urandom, $urandom};
    end else if (access_en && write_en) begin
      mem[access_addr] <= write_elem;
    end
  end
  assign read_elem = mem[access_addr];

  task automatic drive(input bit v, input bit w, input int a, input logic [DW-1:0] d, input bit rr);
    bus.request_valid_in    = v;
    bus.request_write_in    = w;
    bus.request_set_addr_in = AW'(a);
    bus.request_data_in     = d;
    bus.response_ready_in   = rr;
  endtask

  task automatic test_reset();
    drive(1, 1, 0, 64'h5, 1);
    repeat (3) @(negedge clk);
    scramble = 1'b0;
    #1;
    checks++; if (bus.request_ready_out !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b want=0", bus.request_ready_out); end
    checks++; if (access_en !== 1'b0) begin failures++; $display("FAIL reset_access_en got=%b want=0", access_en); end
    checks++; if (write_en !== 1'b0) begin failures++; $display("FAIL reset_write_en got=%b want=0", write_en); end
    checks++; if (bus.response_valid_out !== 1'b0) begin failures++; $display("FAIL reset_resp_valid got=%b want=0", bus.response_valid_out); end
    checks++; if (bus.response_data_out !== '0) begin failures++; $display("FAIL reset_resp_data got=%h want=0", bus.response_data_out); end
    checks++; if (init_done !== 1'b0) begin failures++; $display("FAIL reset_init_done got=%b want=0", init_done); end
    $display("reset: ready=%b access_en=%b init_done=%b", bus.request_ready_out, access_en, init_done);
  endtask

  // Called at the negedge where reset_in has just dropped (cycle 0).
  task automatic test_init_sweep();
    int bad;
    bad = 0;
    for (int c = 0; c < NS; c++) begin
      drive(1, $urandom_range(0, 1), $urandom_range(0, NS - 1), {$urandom, $urandom}, 1);
      #1;
      checks++;
      if (access_en !== 1'b1 || write_en !== 1'b1 || access_addr !== AW'(c) || write_elem !== '0 ||
          bus.request_ready_out !== 1'b0 || init_done !== 1'b0 || bus.response_valid_out !== 1'b0) begin
        failures++; bad++;
        $display("FAIL sweep_cycle_%0d got en=%b we=%b addr=%0d wd=%h rdy=%b done=%b rv=%b want en=1 we=1 addr=%0d wd=0 rdy=0 done=0 rv=0",
                 c, access_en, write_en, access_addr, write_elem, bus.request_ready_out, init_done,
                 bus.response_valid_out, c);
      end
      @(negedge clk);
    end
    drive(0, 0, 0, '0, 1);
    #1;
    checks++; if (init_done !== 1'b1) begin failures++; $display("FAIL sweep_done got=%b want=1", init_done); end
    checks++; if (bus.request_ready_out !== 1'b1) begin failures++; $display("FAIL sweep_ready got=%b want=1", bus.request_ready_out); end
    checks++; if (access_en !== 1'b0) begin failures++; $display("FAIL sweep_idle_access got=%b want=0", access_en); end
    for (int i = 0; i < NS; i++) ref_mem[i] = '0;
    $display("init sweep: %0d bad cycles, init_done=%b at cycle %0d", bad, init_done, NS);
  endtask

  task automatic test_write_read();
    @(negedge clk);
    drive(1, 1, 5, 64'hDEAD_BEEF, 1);
    #1;
    checks++;
    if (bus.request_ready_out !== 1'b1 || access_en !== 1'b1 || write_en !== 1'b1 ||
        access_addr !== AW'(5) || write_elem !== 64'hDEAD_BEEF) begin
      failures++;
      $display("FAIL wr_drive got rdy=%b en=%b we=%b addr=%0d wd=%h want 1 1 1 5 deadbeef",
               bus.request_ready_out, access_en, write_en, access_addr, write_elem);
    end
    ref_mem[5] = 64'hDEAD_BEEF;
    @(negedge clk);
    checks++; if (bus.response_valid_out !== WACK) begin failures++; $display("FAIL wr_no_resp got=%b want=%b", bus.response_valid_out, WACK); end
    drive(1, 0, 5, {$urandom, $urandom}, 1);
    #1;
    checks++; if (access_en !== 1'b1 || write_en !== 1'b0) begin failures++; $display("FAIL rd_drive got en=%b we=%b want en=1 we=0", access_en, write_en); end
    @(negedge clk);
    drive(0, 0, 0, '0, 1);
    checks++;
    if (bus.response_valid_out !== 1'b1 || bus.response_data_out !== 64'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rd_after_wr got v=%b d=%h want v=1 d=deadbeef", bus.response_valid_out, bus.response_data_out);
    end
    $display("write/read set 5: resp v=%b d=%h", bus.response_valid_out, bus.response_data_out);
    @(negedge clk);
    checks++; if (bus.response_valid_out !== 1'b0) begin failures++; $display("FAIL rd_consumed got=%b want=0", bus.response_valid_out); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] vals [3];
    for (int i = 0; i < 3; i++) begin
      vals[i] = {$urandom, $urandom};
      @(negedge clk);
      drive(1, 1, i + 1, vals[i], 1);
      ref_mem[i + 1] = vals[i];
    end
    @(negedge clk);
    drive(0, 0, 0, '0, 1);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      if (i > 0) begin
        checks++;
        if (bus.response_valid_out !== 1'b1 || bus.response_data_out !== vals[i - 1]) begin
          failures++;
          $display("FAIL b2b_resp_%0d got v=%b d=%h want v=1 d=%h", i - 1, bus.response_valid_out, bus.response_data_out, vals[i - 1]);
        end
      end
      drive(1, 0, i + 1, '0, 1);
      #1;
      checks++; if (bus.request_ready_out !== 1'b1) begin failures++; $display("FAIL b2b_ready_%0d got=%b want=1", i, bus.request_ready_out); end
    end
    @(negedge clk);
    drive(0, 0, 0, '0, 1);
    checks++;
    if (bus.response_valid_out !== 1'b1 || bus.response_data_out !== vals[2]) begin
      failures++;
      $display("FAIL b2b_resp_2 got v=%b d=%h want v=1 d=%h", bus.response_valid_out, bus.response_data_out, vals[2]);
    end
    $display("back-to-back reads sets 1..3: last d=%h", bus.response_data_out);
    @(negedge clk);
    checks++; if (bus.response_valid_out !== 1'b0) begin failures++; $display("FAIL b2b_drain got=%b want=0", bus.response_valid_out); end
  endtask

  task automatic test_backpressure();
    @(negedge clk);
    drive(1, 0, 1, '0, 0);
    @(negedge clk);
    drive(1, 0, 2, '0, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      checks++;
      if (bus.request_ready_out !== 1'b0 || access_en !== 1'b0 || bus.response_valid_out !== 1'b1 ||
          bus.response_data_out !== ref_mem[1]) begin
        failures++;
        $display("FAIL bp_hold_%0d got rdy=%b en=%b v=%b d=%h want rdy=0 en=0 v=1 d=%h",
                 i, bus.request_ready_out, access_en, bus.response_valid_out, bus.response_data_out, ref_mem[1]);
      end
      @(negedge clk);
    end
    bus.response_ready_in = 1'b1;
    #1;
    checks++; if (bus.request_ready_out !== 1'b1 || access_en !== 1'b1) begin failures++; $display("FAIL bp_release got rdy=%b en=%b want 1 1", bus.request_ready_out, access_en); end
    @(negedge clk);
    drive(0, 0, 0, '0, 1);
    checks++;
    if (bus.response_valid_out !== 1'b1 || bus.response_data_out !== ref_mem[2]) begin
      failures++;
      $display("FAIL bp_next_resp got v=%b d=%h want v=1 d=%h", bus.response_valid_out, bus.response_data_out, ref_mem[2]);
    end
    $display("backpressure: released, next d=%h", bus.response_data_out);
    @(negedge clk);
  endtask

  task automatic test_write_ack();
    @(negedge clk);
    drive(1, 1, 9, 64'h1234, 1);
    ref_mem[9] = 64'h1234;
    @(negedge clk);
    drive(1, 0, 9, '0, 1);
    checks++;
    if (bus.response_valid_out !== WACK || (WACK && bus.response_data_out !== 64'h1234)) begin
      failures++;
      $display("FAIL write_ack got v=%b d=%h want v=%b d=1234", bus.response_valid_out, bus.response_data_out, WACK);
    end
    @(negedge clk);
    drive(0, 0, 0, '0, 1);
    checks++;
    if (bus.response_valid_out !== 1'b1 || bus.response_data_out !== 64'h1234) begin
      failures++;
      $display("FAIL write_ack_readback got v=%b d=%h want v=1 d=1234", bus.response_valid_out, bus.response_data_out);
    end
    $display("write set 9=1234: ack expected=%b readback d=%h", WACK, bus.response_data_out);
    @(negedge clk);
  endtask

  task automatic test_random(input int n);
    bit            mv;
    logic [DW-1:0] md;
    bit            v, w, rr, exp_rdy, acc;
    int            a;
    logic [DW-1:0] d;
    mv = 1'b0;
    md = '0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      checks++;
      if (bus.response_valid_out !== mv || (mv && bus.response_data_out !== md)) begin
        failures++;
        $display("FAIL rand_resp_%0d got v=%b d=%h want v=%b d=%h", i, bus.response_valid_out, bus.response_data_out, mv, md);
      end
      v  = ($urandom_range(0, 3) != 0);
      w  = ($urandom_range(0, 2) == 0);
      a  = $urandom_range(0, NS - 1);
      d  = {$urandom, $urandom};
      rr = ($urandom_range(0, 3) != 0);
      drive(v, w, a, d, rr);
      #1;
      exp_rdy = !mv || rr;
      acc     = v && exp_rdy;
      checks++;
      if (bus.request_ready_out !== exp_rdy || access_en !== acc || write_en !== (acc && w)) begin
        failures++;
        $display("FAIL rand_drive_%0d got rdy=%b en=%b we=%b want rdy=%b en=%b we=%b",
                 i, bus.request_ready_out, access_en, write_en, exp_rdy, acc, acc && w);
      end
      if (acc && !w) begin
        mv = 1'b1; md = ref_mem[a];
      end else if (acc && w && WACK) begin
        mv = 1'b1; md = d;
      end else if (rr) begin
        mv = 1'b0;
      end
      if (acc && w) ref_mem[a] = d;
    end
    @(negedge clk);
    drive(0, 0, 0, '0, 1);
    @(negedge clk);
    checks++; if (bus.response_valid_out !== 1'b0) begin failures++; $display("FAIL rand_drain got=%b want=0", bus.response_valid_out); end
    $display("random traffic: %0d cycles done", n);
  endtask

  task automatic test_reset_midsweep();
    @(negedge clk);
    drive(1, 0, 7, '0, 0);
    @(negedge clk);
    checks++; if (bus.response_valid_out !== 1'b1) begin failures++; $display("FAIL pend_setup got=%b want=1", bus.response_valid_out); end
    rst = 1'b1;
    drive(1, 1, 3, {$urandom, $urandom}, 0);
    #1;
    checks++;
    if (bus.request_ready_out !== 1'b0 || access_en !== 1'b0 || write_en !== 1'b0) begin
      failures++;
      $display("FAIL rst_gating got rdy=%b en=%b we=%b want 0 0 0", bus.request_ready_out, access_en, write_en);
    end
    @(negedge clk);
    checks++;
    if (bus.response_valid_out !== 1'b0 || bus.response_data_out !== '0 || init_done !== 1'b0) begin
      failures++;
      $display("FAIL rst_pending got v=%b d=%h done=%b want 0 0 0", bus.response_valid_out, bus.response_data_out, init_done);
    end
    rst = 1'b0;
    drive(0, 0, 0, '0, 1);
    for (int c = 0; c < 20; c++) begin
      #1;
      checks++; if (access_addr !== AW'(c) || access_en !== 1'b1) begin failures++; $display("FAIL partial_sweep_%0d got addr=%0d en=%b want addr=%0d en=1", c, access_addr, access_en, c); end
      @(negedge clk);
    end
    rst = 1'b1;
    #1;
    checks++; if (access_en !== 1'b0) begin failures++; $display("FAIL midsweep_gate got=%b want=0", access_en); end
    @(negedge clk);
    rst = 1'b0;
    $display("reset at sweep cycle 20: sweep restarts");
    test_init_sweep();
  endtask

  initial begin
    test_reset();
    rst = 1'b0;
    test_init_sweep();
    test_write_read();
    test_back_to_back();
    test_backpressure();
    test_write_ack();
    test_random(400);
    test_reset_midsweep();
    test_random(200);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lutram_port_controller.md
# lutram_port_controller

Initiator-side front end for the single-port LUTRAM storage used in the core's caches and tables. It turns a valid/ready request stream from a client pipeline into cycle-accurate storage port accesses. It also clears every set after reset and returns read data on a registered valid/ready response channel. The block drives the storage's access, write and address pins and consumes its combinational read data.

## Interface
Parameters:
- SINGLE_ELEMENT_SIZE_IN_BITS, 64, element width
- NUMBER_SETS, 64, number of storage sets (need not be a power of two)
- SET_PTR_WIDTH_IN_BITS, $clog2(NUMBER_SETS), set address width

Ports:
- clk_in  in  1  clock; all logic on rising edge
- reset_in  in  1  synchronous, active-high reset
- request_valid_in  in  1  client request present
- request_ready_out  out  1  controller accepts request this cycle
- request_write_in  in  1  1 = write, 0 = read
- request_set_addr_in  in  SET_PTR_WIDTH_IN_BITS  target set
- request_data_in  in  SINGLE_ELEMENT_SIZE_IN_BITS  write data
- response_valid_out  out  1  response_data_out holds a valid response
- response_ready_in  in  1  client consumes response
- response_data_out  out  SINGLE_ELEMENT_SIZE_IN_BITS  read data (or write echo, see Configuration)
- init_done_out  out  1  clear sweep finished; requests may be accepted
- access_en_out  out  1  storage access enable
- write_en_out  out  1  storage write enable
- access_set_addr_out  out  SET_PTR_WIDTH_IN_BITS  storage set address
- write_element_out  out  SINGLE_ELEMENT_SIZE_IN_BITS  storage write data
- read_element_in  in  SINGLE_ELEMENT_SIZE_IN_BITS  storage combinational read data

## Operation
- The FSM has two states:
  - INIT: a sweep counter walks sets 0..NUMBER_SETS-1, one per cycle, with access_en_out=1, write_en_out=1 and write_element_out=0. After set NUMBER_SETS-1 is written, the FSM moves to RUN.
  - RUN: normal service. There is no exit except reset.
- Accept condition: request_ready_out = RUN && (!response_valid_out || response_ready_in). A request is accepted at an edge where request_valid_in && request_ready_out.
- Storage drive in RUN is combinational from the request:
  - access_en_out = request_valid_in && request_ready_out
  - write_en_out = access_en_out && request_write_in
  - access_set_addr_out = request_set_addr_in
  - write_element_out = request_data_in
- Accepted write: storage is updated at the accepting edge. With the macro off, no response is produced.
- Accepted read: read_element_in is captured into response_data_out at the accepting edge, and response_valid_out is set.
- Response handshake:
  - response_valid_out clears on an edge with response_ready_in=1, unless a new response is loaded at that same edge.
  - response_data_out is stable while valid && !ready.
- Outputs are don't-care when their enables are low, but they must be driven deterministically, with no X.
- Reset (any cycle, including mid-sweep or with a response pending) forces:
  - FSM=INIT, sweep counter=0, init_done_out=0, response_valid_out=0, response_data_out=0
  - request_ready_out=0 while reset_in=1, and access_en_out=0, write_en_out=0 while reset_in=1
- The sweep counter saturates at NUMBER_SETS-1 and never addresses a set ≥ NUMBER_SETS.

## Timing
- Cycle 0 is the first cycle with reset_in=0.
  - Cycles 0..NUMBER_SETS-1 write sets 0..NUMBER_SETS-1.
  - init_done_out=1 and request_ready_out can be 1 from cycle NUMBER_SETS.
- Read latency is 1 cycle: request accepted at edge k, so response_valid_out=1 from cycle k+1.
- Full throughput: one request per cycle when response_ready_in is held at 1.
- Simultaneous response consume and new read accept: the new data replaces the old with no bubble, and response_valid_out stays 1.
- A write followed by a read to the same set on the next cycle returns the new data.
- A read in the same cycle as a write cannot occur, because the port is single.

## Configuration
- LUTRAM_PORT_CONTROLLER_WRITE_ACK_EN:
  - Defined: an accepted write also produces a response, with response_data_out = request_data_in and the same handshake and latency as a read.
  - Undefined: writes are posted, and response_valid_out is never set by a write.

## Structure
- A shared package holds:
  - the FSM state encoding (INIT, RUN)
  - a helper constant for the sweep terminal count (NUMBER_SETS-1, width SET_PTR_WIDTH_IN_BITS)
- One natural sub-module: lutram_port_response_reg, the one-entry response holding register with the valid/ready handshake. It is reusable by other storage front ends.
- The storage itself is instantiated by the parent, not inside this block.

## Test plan
- Reset then idle, NUMBER_SETS=64: writes to sets 0..63 with data 0; init_done_out rises in cycle 64; no request accepted before cycle 64.
- Write set 5 = 0xDEAD_BEEF, then read set 5 next cycle: response_data_out=0xDEAD_BEEF, response_valid_out=1 one cycle after the read is accepted.
- Back-to-back reads of sets 1,2,3 with response_ready_in=1: three consecutive valid responses, no bubbles, request_ready_out stays 1.
- Read with response_ready_in=0 for 3 cycles: request_ready_out=0, response_data_out held; ready=1 releases it, and a new read is accepted in that same cycle.
- Assert reset_in at sweep cycle 20 with a response pending: response_valid_out=0 next edge, and the sweep restarts from set 0.
- With LUTRAM_PORT_CONTROLLER_WRITE_ACK_EN: write set 9 = 0x1234 gives response 0x1234 after 1 cycle. Without the macro: no response.
